// File: rtl/register_read_stage.sv
// rtl/register_read_stage.sv - register read stage: regfile, operand forwarding, rr_* pipeline register
//
// Purpose:
//   Sits between decode and memory_stage. Owns the 16x32 register file, resolves
//   rs/rt with forwarding in the cycle an instruction is latched, and drives the
//   rr_* pipeline register. A LW/SW is held in rr_* for the whole bus transaction
//   while decode is back-pressured through rr_stall.
//
// Optional feature (macro RR_PERF_EN):
//   Adds saturating counters rr_hold_cycles (cycles not in RUN) and
//   rr_flush_count (flush events).
//
// Ports:
//   i_clk, i_reset_n              clock, asynchronous active-low reset
//   dec_valid/op/altop/rd/rs/rt   decoded instruction from decode
//   dec_imm32, dec_pc             sign-extended immediate, instruction PC
//   rr_stall                      decode must hold its outputs this cycle
//   mem_stall                     memory_stage busy
//   mem_flush, writeback_flush    squash requests
//   mem_of_reg/val                early forward from memory_stage (reg 0 = none)
//   mem_rd/mem_rd_val             memory_stage output buffer (reg 0 = none)
//   wr_rd/wr_val                  register-file write port (reg 0 = none)
//   rr_valid/op/altop/rd          pipeline register to memory_stage
//   rr_rs_val/rt_val/imm32/pc     pipeline register to memory_stage
//   rr_hold_cycles, rr_flush_count  performance counters (RR_PERF_EN only)

module register_read_stage #(
  parameter int NREGS            = 16,
  parameter int DATA_W           = 32,
  parameter int R0_ZERO          = 1,
  parameter logic [5:0] OPCODE_LW = 6'h23,
  parameter logic [5:0] OPCODE_SW = 6'h2B
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              dec_valid,
  input  logic [5:0]        dec_op,
  input  logic [7:0]        dec_altop,
  input  logic [3:0]        dec_rd,
  input  logic [3:0]        dec_rs,
  input  logic [3:0]        dec_rt,
  input  logic [DATA_W-1:0] dec_imm32,
  input  logic [DATA_W-1:0] dec_pc,
  output logic              rr_stall,
  input  logic              mem_stall,
  input  logic              mem_flush,
  input  logic              writeback_flush,
  input  logic [3:0]        mem_of_reg,
  input  logic [DATA_W-1:0] mem_of_val,
  input  logic [3:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_rd_val,
  input  logic [3:0]        wr_rd,
  input  logic [DATA_W-1:0] wr_val,
  output logic              rr_valid,
  output logic [5:0]        rr_op,
  output logic [7:0]        rr_altop,
  output logic [3:0]        rr_rd,
  output logic [DATA_W-1:0] rr_rs_val,
  output logic [DATA_W-1:0] rr_rt_val,
  output logic [DATA_W-1:0] rr_imm32,
  output logic [DATA_W-1:0] rr_pc
`ifdef RR_PERF_EN
  ,
  output logic [31:0]       rr_hold_cycles,
  output logic [15:0]       rr_flush_count
`endif
);

  typedef enum logic [1:0] {RUN, MEM_ISSUE, MEM_BUSY, DRAIN} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] regs [NREGS];
  logic              flush, memop, load, wr_en;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  // Index 0 is the "no register" marker on every forward port when r0 is hardwired.
  function automatic logic idx_hit(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && ((a != 4'd0) || (R0_ZERO == 0));
  endfunction

  function automatic logic [DATA_W-1:0] resolve(
    input logic [3:0]        idx,
    input logic [3:0]        of_reg,
    input logic [DATA_W-1:0] of_val,
    input logic [3:0]        m_rd,
    input logic [DATA_W-1:0] m_val,
    input logic [3:0]        w_rd,
    input logic [DATA_W-1:0] w_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (idx_hit(of_reg, idx))                 return of_val;
    else if (idx_hit(m_rd, idx))              return m_val;
    else if (idx_hit(w_rd, idx))              return w_val;
    else if ((R0_ZERO != 0) && (idx == 4'd0)) return '0;
    else                                      return rf_val;
  endfunction

  assign flush = mem_flush | writeback_flush;
  assign memop = rr_valid && ((rr_op == OPCODE_LW) || (rr_op == OPCODE_SW));
  assign wr_en = (wr_rd != 4'd0) || (R0_ZERO == 0);

  always_comb begin
    rs_fwd = resolve(dec_rs, mem_of_reg, mem_of_val, mem_rd, mem_rd_val, wr_rd, wr_val, regs[dec_rs]);
    rt_fwd = resolve(dec_rt, mem_of_reg, mem_of_val, mem_rd, mem_rd_val, wr_rd, wr_val, regs[dec_rt]);
  end

  // Register file; the write still lands in a flush cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_rd] <= wr_val;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= RUN;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      RUN: begin
        if (memop) next_state = MEM_ISSUE;
        else       load       = 1'b1;
      end
      MEM_ISSUE: next_state = mem_stall ? MEM_BUSY : DRAIN;
      MEM_BUSY:  if (!mem_stall) next_state = DRAIN;
      DRAIN: begin
        load       = 1'b1;
        next_state = RUN;
      end
      default: next_state = RUN;
    endcase
    if (flush) begin
      next_state = RUN;
      load       = 1'b0;
    end
    // A flush swallows the decode instruction, so decode must not hold it.
    rr_stall = dec_valid && !flush && (state != DRAIN) && !((state == RUN) && !memop);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n || flush) begin
      rr_valid  <= 1'b0;
      rr_op     <= '0;
      rr_altop  <= '0;
      rr_rd     <= '0;
      rr_rs_val <= '0;
      rr_rt_val <= '0;
      rr_imm32  <= '0;
      rr_pc     <= '0;
    end else if (load) begin
      rr_valid  <= dec_valid;
      rr_op     <= dec_op;
      rr_altop  <= dec_altop;
      rr_rd     <= dec_rd;
      rr_rs_val <= rs_fwd;
      rr_rt_val <= rt_fwd;
      rr_imm32  <= dec_imm32;
      rr_pc     <= dec_pc;
    end
  end

`ifdef RR_PERF_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_hold_cycles <= '0;
      rr_flush_count <= '0;
    end else begin
      if ((state != RUN) && (rr_hold_cycles != '1)) rr_hold_cycles <= rr_hold_cycles + 32'd1;
      if (flush && (rr_flush_count != '1))          rr_flush_count <= rr_flush_count + 16'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_register_read_stage.sv
// tb/tb_register_read_stage.sv - self-checking bench for register_read_stage
module tb_register_read_stage;

  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic        clk, rst_n;
  logic        dec_valid;
  logic [5:0]  dec_op;
  logic [7:0]  dec_altop;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic [31:0] dec_imm32, dec_pc;
  logic        rr_stall, mem_stall, mem_flush, writeback_flush;
  logic [3:0]  mem_of_reg, mem_rd, wr_rd;
  logic [31:0] mem_of_val, mem_rd_val, wr_val;
  logic        rr_valid;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd;
  logic [31:0] rr_rs_val, rr_rt_val, rr_imm32, rr_pc;
`ifdef RR_PERF_EN
  logic [31:0] rr_hold_cycles;
  logic [15:0] rr_flush_count;
`endif

  int tests = 0;
  int fails = 0;

  register_read_stage dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_altop(dec_altop),
    .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_imm32(dec_imm32), .dec_pc(dec_pc),
    .rr_stall(rr_stall), .mem_stall(mem_stall),
    .mem_flush(mem_flush), .writeback_flush(writeback_flush),
    .mem_of_reg(mem_of_reg), .mem_of_val(mem_of_val),
    .mem_rd(mem_rd), .mem_rd_val(mem_rd_val),
    .wr_rd(wr_rd), .wr_val(wr_val),
    .rr_valid(rr_valid), .rr_op(rr_op), .rr_altop(rr_altop), .rr_rd(rr_rd),
    .rr_rs_val(rr_rs_val), .rr_rt_val(rr_rt_val), .rr_imm32(rr_imm32), .rr_pc(rr_pc)
`ifdef RR_PERF_EN
    , .rr_hold_cycles(rr_hold_cycles), .rr_flush_count(rr_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm, pc;
    logic [3:0]  wrd;  logic [31:0] wval;
    logic [3:0]  mrd;  logic [31:0] mval;
    logic [3:0]  ofr;  logic [31:0] ofv;
    logic [31:0] e_rs, e_rt;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic dv, input logic [3:0] rd, input logic [3:0] rs,
                              input logic [3:0] rt, input logic [31:0] imm,
                              input logic [3:0] wrd, input logic [31:0] wval,
                              input logic [3:0] mrd, input logic [31:0] mval,
                              input logic [3:0] ofr, input logic [31:0] ofv,
                              input logic [31:0] e_rs, input logic [31:0] e_rt);
    vec_t v;
    v.dv = dv; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm; v.pc = imm + 32'h1000;
    v.wrd = wrd; v.wval = wval; v.mrd = mrd; v.mval = mval; v.ofr = ofr; v.ofv = ofv;
    v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic dv, input logic [5:0] op, input logic [3:0] rd,
                         input logic [3:0] rs, input logic [3:0] rt);
    dec_valid = dv; dec_op = op; dec_rd = rd; dec_rs = rs; dec_rt = rt;
    dec_altop = 8'h5A; dec_imm32 = {28'h0, rd}; dec_pc = {24'h0, 2'b0, op};
  endtask

  task automatic clr_fwd();
    wr_rd = 0; wr_val = 0; mem_rd = 0; mem_rd_val = 0; mem_of_reg = 0; mem_of_val = 0;
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 0; mem_flush = 0; writeback_flush = 0;
    clr_fwd();
    set_dec(1'b1, OP_ADD, 4'd1, 4'd1, 4'd1);

    // Reset state
    #2;
    chk("reset_valid", {31'b0, rr_valid}, 0);
    chk("reset_op", {26'b0, rr_op}, 0);
    chk("reset_rs_val", rr_rs_val, 0);
    chk("reset_stall", {31'b0, rr_stall}, 0);
    #10 rst_n = 1'b1;

    // Table: forwarding priority, regfile, same-cycle bypass, r0
    vecs[0] = mk(1, 1, 7, 8, 32'h100, 3, 32'h11, 0, 0, 0, 0, 32'h0, 32'h0);
    vecs[1] = mk(1, 2, 3, 0, 32'h104, 3, 32'h22, 3, 32'h33, 3, 32'h44, 32'h44, 32'h0);
    vecs[2] = mk(1, 2, 3, 0, 32'h108, 3, 32'h22, 3, 32'h33, 0, 32'h44, 32'h33, 32'h0);
    vecs[3] = mk(1, 2, 3, 0, 32'h10C, 3, 32'h22, 0, 32'h33, 0, 0, 32'h22, 32'h0);
    vecs[4] = mk(1, 4, 3, 3, 32'h110, 5, 32'h55, 0, 0, 0, 0, 32'h22, 32'h22);
    vecs[5] = mk(1, 4, 5, 3, 32'h114, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h55, 32'h22);
    vecs[6] = mk(1, 4, 0, 5, 32'h118, 0, 32'hFFFF_FFFF, 0, 32'hABCD, 0, 32'h1234, 32'h0, 32'h55);
    vecs[7] = mk(1, 8, 5, 6, 32'h11C, 6, 32'h66, 5, 32'h77, 0, 0, 32'h77, 32'h66);
    vecs[8] = mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      dec_valid = vecs[i].dv; dec_op = vecs[i].dv ? OP_ADD : 6'd0; dec_altop = 8'h00;
      dec_rd = vecs[i].rd; dec_rs = vecs[i].rs; dec_rt = vecs[i].rt;
      dec_imm32 = vecs[i].imm; dec_pc = vecs[i].pc;
      wr_rd = vecs[i].wrd; wr_val = vecs[i].wval;
      mem_rd = vecs[i].mrd; mem_rd_val = vecs[i].mval;
      mem_of_reg = vecs[i].ofr; mem_of_val = vecs[i].ofv;
      #1 chk($sformatf("v%0d_stall", i), {31'b0, rr_stall}, 0);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, rr_valid}, {31'b0, vecs[i].dv});
      chk($sformatf("v%0d_op", i), {26'b0, rr_op}, vecs[i].dv ? {26'b0, OP_ADD} : 32'h0);
      chk($sformatf("v%0d_rd", i), {28'b0, rr_rd}, {28'b0, vecs[i].rd});
      chk($sformatf("v%0d_rs_val", i), rr_rs_val, vecs[i].e_rs);
      chk($sformatf("v%0d_rt_val", i), rr_rt_val, vecs[i].e_rt);
      chk($sformatf("v%0d_imm", i), rr_imm32, vecs[i].imm);
      chk($sformatf("v%0d_pc", i), rr_pc, vecs[i].pc);
    end
    clr_fwd();

    // LW hold with 4 busy cycles, then load-use ADD r6<-r5 takes mem_rd_val
    set_dec(1, OP_LW, 4'd5, 4'd1, 4'd0);
    #1 chk("lw_issue_stall", {31'b0, rr_stall}, 0);
    step();
    chk("lw_latched_op", {26'b0, rr_op}, {26'b0, OP_LW});
    set_dec(1, OP_ADD, 4'd6, 4'd5, 4'd0);
    for (int c = 0; c < 6; c++) begin
      mem_stall = (c >= 1 && c <= 4);
      if (c == 5) begin mem_rd = 4'd5; mem_rd_val = 32'hDEADBEEF; end
      #1 chk($sformatf("lw_hold%0d_stall", c), {31'b0, rr_stall}, 1);
      step();
      chk($sformatf("lw_hold%0d_op", c), {26'b0, rr_op}, {26'b0, OP_LW});
      chk($sformatf("lw_hold%0d_rd", c), {28'b0, rr_rd}, 5);
    end
    mem_stall = 0;
    #1 chk("drain_stall", {31'b0, rr_stall}, 0);
    step();
    chk("loaduse_op", {26'b0, rr_op}, {26'b0, OP_ADD});
    chk("loaduse_rd", {28'b0, rr_rd}, 6);
    chk("loaduse_rs_val", rr_rs_val, 32'hDEADBEEF);
`ifdef RR_PERF_EN
    chk("perf_hold_cycles", rr_hold_cycles, 6);
`endif
    clr_fwd();
    set_dec(0, 6'd0, 4'd0, 4'd0, 4'd0);
    step();
    chk("post_lw_bubble", {31'b0, rr_valid}, 0);

    // Instant SW: MEM_ISSUE -> DRAIN, next instruction 2 cycles after hold starts
    set_dec(1, OP_SW, 4'd0, 4'd3, 4'd5);
    step();
    chk("sw_op", {26'b0, rr_op}, {26'b0, OP_SW});
    chk("sw_rt_val", rr_rt_val, 32'h55);
    set_dec(1, OP_ADD, 4'd2, 4'd3, 4'd0);
    for (int c = 0; c < 2; c++) begin
      #1 chk($sformatf("sw_hold%0d_stall", c), {31'b0, rr_stall}, 1);
      step();
      chk($sformatf("sw_hold%0d_op", c), {26'b0, rr_op}, {26'b0, OP_SW});
    end
    #1 chk("sw_drain_stall", {31'b0, rr_stall}, 0);
    step();
    chk("sw_next_op", {26'b0, rr_op}, {26'b0, OP_ADD});
    chk("sw_next_rs_val", rr_rs_val, 32'h22);

    // Flush during MEM_BUSY with decode valid; regfile write in flush cycle lands
    set_dec(1, OP_LW, 4'd7, 4'd0, 4'd0);
    step();
    set_dec(1, OP_ADD, 4'd9, 4'd9, 4'd0);
    step();                         // RUN -> MEM_ISSUE
    mem_stall = 1;
    step();                         // MEM_ISSUE -> MEM_BUSY
    writeback_flush = 1; wr_rd = 4'd9; wr_val = 32'h99;
    #1 chk("flush_stall", {31'b0, rr_stall}, 0);
    step();
    writeback_flush = 0; mem_stall = 0; clr_fwd();
    chk("flush_valid", {31'b0, rr_valid}, 0);
    chk("flush_op", {26'b0, rr_op}, 0);
    chk("flush_rs_val", rr_rs_val, 0);
    #1 chk("post_flush_stall", {31'b0, rr_stall}, 0);
    step();
    chk("post_flush_op", {26'b0, rr_op}, {26'b0, OP_ADD});
    chk("post_flush_rs_val", rr_rs_val, 32'h99);

    // Async reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'b0, rr_valid}, 0);
    chk("areset_op", {26'b0, rr_op}, 0);
    chk("areset_rs_val", rr_rs_val, 0);
    chk("areset_stall", {31'b0, rr_stall}, 0);
    #1 rst_n = 1'b1;
    set_dec(1, OP_ADD, 4'd1, 4'd3, 4'd9);
    step();
    chk("areset_regfile_r3", rr_rs_val, 0);
    chk("areset_regfile_r9", rr_rt_val, 0);
    chk("areset_after_valid", {31'b0, rr_valid}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
